// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with STAT/RX/TX registers, TX/RX FIFOs,
// a serial transmitter and a synchronised serial receiver.
module uart_mmio #(
  parameter int CLKDIV  = 16,
  parameter int FIFO_LG = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [3:0]  bus_wmask,
  input  logic [31:0] bus_wdata,
  output logic        bus_resp,
  output logic [31:0] bus_rdata,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int DEPTH = 1 << FIFO_LG;
  localparam int BW    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  localparam logic [BW-1:0]    BAUD_FULL = BW'(CLKDIV - 1);
  localparam logic [BW-1:0]    BAUD_HALF = BW'(CLKDIV / 2 - 1);
  localparam logic [BW-1:0]    BAUD_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0]    BAUD_ONE  = {{(BW - 1){1'b0}}, 1'b1};
  localparam logic [FIFO_LG:0] PTR_ONE   = {{FIFO_LG{1'b0}}, 1'b1};

  localparam logic [1:0] ADDR_STAT = 2'd0;
  localparam logic [1:0] ADDR_RX   = 2'd1;
  localparam logic [1:0] ADDR_TX   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_st_e;

  // Bus response registers and sticky flags
  logic        resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ovr_q, ovr_d;
  logic        ferr_q, ferr_d;

  // TX FIFO
  logic [7:0]       tx_mem_q [DEPTH];
  logic [7:0]       tx_mem_d [DEPTH];
  logic [FIFO_LG:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;

  // RX FIFO
  logic [7:0]       rx_mem_q [DEPTH];
  logic [7:0]       rx_mem_d [DEPTH];
  logic [FIFO_LG:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;

  // TX engine
  uart_st_e    tx_state_q, tx_state_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [BW-1:0] tx_baud_q, tx_baud_d;
  logic        tx_line_q, tx_line_d;

  // RX engine
  logic [1:0]  rx_sync_q, rx_sync_d;
  uart_st_e    rx_state_q, rx_state_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [BW-1:0] rx_baud_q, rx_baud_d;

  // Combinational status and handshakes
  logic tx_empty_s, tx_full_s, tx_idle_empty_s, rx_empty_s, rx_full_s;
  logic rd_stat_s, rd_rx_s, wr_tx_s;
  logic tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic ovr_set_s, ferr_set_s, rx_bit_s;
  logic [7:0] tx_head_s, rx_head_s;
  logic unused_s;

  assign tx_empty_s = (tx_wptr_q == tx_rptr_q);
  assign tx_full_s  = (tx_wptr_q[FIFO_LG] != tx_rptr_q[FIFO_LG]) &&
                      (tx_wptr_q[FIFO_LG-1:0] == tx_rptr_q[FIFO_LG-1:0]);
  assign rx_empty_s = (rx_wptr_q == rx_rptr_q);
  assign rx_full_s  = (rx_wptr_q[FIFO_LG] != rx_rptr_q[FIFO_LG]) &&
                      (rx_wptr_q[FIFO_LG-1:0] == rx_rptr_q[FIFO_LG-1:0]);
  assign tx_idle_empty_s = tx_empty_s && (tx_state_q == ST_IDLE);
  assign tx_head_s  = tx_mem_q[tx_rptr_q[FIFO_LG-1:0]];
  assign rx_head_s  = rx_mem_q[rx_rptr_q[FIFO_LG-1:0]];
  assign rx_bit_s   = rx_sync_q[1];

  assign rd_stat_s = bus_req && !bus_we && (bus_addr == ADDR_STAT);
  assign rd_rx_s   = bus_req && !bus_we && (bus_addr == ADDR_RX);
  assign wr_tx_s   = bus_req &&  bus_we && (bus_addr == ADDR_TX) && bus_wmask[0];
  assign rx_pop_s  = rd_rx_s && !rx_empty_s;
  // A pop by the transmitter in the same cycle frees the slot for the write.
  assign tx_push_s = wr_tx_s && (!tx_full_s || tx_pop_s);

  // Only the low byte lane carries data; the framing flag is a debug-only sticky bit.
  assign unused_s = ^{bus_wdata[31:8], bus_wmask[3:1], ferr_q};

  assign bus_resp  = resp_q;
  assign bus_rdata = rdata_q;
  assign uart_tx   = tx_line_q;

  // Register read mux, response strobe and overrun flag update (set beats clear)
  always_comb begin
    resp_d  = bus_req;
    rdata_d = 32'h0000_0000;
    if (rd_stat_s) begin
      rdata_d = {27'h000_0000, ovr_q, tx_full_s, tx_idle_empty_s, rx_full_s, rx_empty_s};
    end else if (rx_pop_s) begin
      rdata_d = {24'h00_0000, rx_head_s};
    end else begin
      rdata_d = 32'h0000_0000;
    end
    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (rd_stat_s) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
    ferr_d = ferr_q | ferr_set_s;
  end

  // Bus-side registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_q  <= 1'b0;
      rdata_q <= 32'h0000_0000;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  // FIFO storage and pointer next-state for both directions
  always_comb begin
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    if (tx_push_s) begin
      tx_mem_d[tx_wptr_q[FIFO_LG-1:0]] = bus_wdata[7:0];
      tx_wptr_d = tx_wptr_q + PTR_ONE;
    end else begin
      tx_wptr_d = tx_wptr_q;
    end
    if (tx_pop_s) begin
      tx_rptr_d = tx_rptr_q + PTR_ONE;
    end else begin
      tx_rptr_d = tx_rptr_q;
    end
    if (rx_push_s) begin
      rx_mem_d[rx_wptr_q[FIFO_LG-1:0]] = rx_shift_q;
      rx_wptr_d = rx_wptr_q + PTR_ONE;
    end else begin
      rx_wptr_d = rx_wptr_q;
    end
    if (rx_pop_s) begin
      rx_rptr_d = rx_rptr_q + PTR_ONE;
    end else begin
      rx_rptr_d = rx_rptr_q;
    end
  end

  // FIFO registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_mem_q  <= '{default: 8'h00};
      rx_mem_q  <= '{default: 8'h00};
      tx_wptr_q <= {(FIFO_LG + 1){1'b0}};
      tx_rptr_q <= {(FIFO_LG + 1){1'b0}};
      rx_wptr_q <= {(FIFO_LG + 1){1'b0}};
      rx_rptr_q <= {(FIFO_LG + 1){1'b0}};
    end else begin
      tx_mem_q  <= tx_mem_d;
      rx_mem_q  <= rx_mem_d;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
    end
  end

  // Transmitter: start, 8 data bits LSB first, stop; chains straight into the next byte
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_baud_d  = tx_baud_q;
    tx_line_d  = tx_line_q;
    tx_pop_s   = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        if (!tx_empty_s) begin
          tx_pop_s   = 1'b1;
          tx_shift_d = tx_head_s;
          tx_state_d = ST_START;
          tx_baud_d  = BAUD_FULL;
          tx_line_d  = 1'b0;
        end else begin
          tx_line_d  = 1'b1;
        end
      end
      ST_START: begin
        if (tx_baud_q == BAUD_ZERO) begin
          tx_state_d = ST_DATA;
          tx_baud_d  = BAUD_FULL;
          tx_bit_d   = 3'd0;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_baud_d  = tx_baud_q - BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (tx_baud_q == BAUD_ZERO) begin
          tx_baud_d = BAUD_FULL;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_baud_d = tx_baud_q - BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (tx_baud_q == BAUD_ZERO) begin
          if (!tx_empty_s) begin
            tx_pop_s   = 1'b1;
            tx_shift_d = tx_head_s;
            tx_state_d = ST_START;
            tx_baud_d  = BAUD_FULL;
            tx_line_d  = 1'b0;
          end else begin
            tx_state_d = ST_IDLE;
            tx_line_d  = 1'b1;
          end
        end else begin
          tx_baud_d = tx_baud_q - BAUD_ONE;
        end
      end
      default: begin
        tx_state_d = ST_IDLE;
        tx_line_d  = 1'b1;
      end
    endcase
  end

  // Transmitter registers; the line flop resets high so reset forces the idle level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= ST_IDLE;
      tx_shift_q <= 8'h00;
      tx_bit_q   <= 3'd0;
      tx_baud_q  <= BAUD_ZERO;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_baud_q  <= tx_baud_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // Receiver: mid-bit sampling after a validated start bit, push or flag at the stop sample
  always_comb begin
    rx_sync_d  = {rx_sync_q[0], uart_rx};
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_baud_d  = rx_baud_q;
    rx_push_s  = 1'b0;
    ovr_set_s  = 1'b0;
    ferr_set_s = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (!rx_bit_s) begin
          rx_state_d = ST_START;
          rx_baud_d  = BAUD_HALF;
        end else begin
          rx_state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (rx_baud_q == BAUD_ZERO) begin
          if (!rx_bit_s) begin
            rx_state_d = ST_DATA;
            rx_baud_d  = BAUD_FULL;
            rx_bit_d   = 3'd0;
          end else begin
            rx_state_d = ST_IDLE;
          end
        end else begin
          rx_baud_d = rx_baud_q - BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (rx_baud_q == BAUD_ZERO) begin
          rx_shift_d = {rx_bit_s, rx_shift_q[7:1]};
          rx_baud_d  = BAUD_FULL;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_bit_d   = rx_bit_q + 3'd1;
          end
        end else begin
          rx_baud_d = rx_baud_q - BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (rx_baud_q == BAUD_ZERO) begin
          rx_state_d = ST_IDLE;
          if (rx_bit_s) begin
            // A same-cycle bus pop makes room, so it is not an overrun.
            if (!rx_full_s || rx_pop_s) begin
              rx_push_s = 1'b1;
            end else begin
              ovr_set_s = 1'b1;
            end
          end else begin
            ferr_set_s = 1'b1;
          end
        end else begin
          rx_baud_d = rx_baud_q - BAUD_ONE;
        end
      end
      default: begin
        rx_state_d = ST_IDLE;
      end
    endcase
  end

  // Receiver registers including the two-flop synchroniser (idle-high reset)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= ST_IDLE;
      rx_shift_q <= 8'h00;
      rx_bit_q   <= 3'd0;
      rx_baud_q  <= BAUD_ZERO;
    end else begin
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_baud_q  <= rx_baud_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: scoreboard bench for uart_mmio. Expected bus read data and
// expected serial TX bytes are queued when stimulus is issued and checked
// when the DUT responds or a frame is decoded off uart_tx.
module tb_uart_mmio;

  localparam int CLKDIV  = 16;
  localparam int FIFO_LG = 3;
  localparam int FRAME   = 10 * CLKDIV;

  localparam logic [1:0] A_STAT = 2'd0;
  localparam logic [1:0] A_RX   = 2'd1;
  localparam logic [1:0] A_TX   = 2'd2;
  localparam logic [1:0] A_RSV  = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [3:0]  bus_wmask = 4'h0;
  logic [31:0] bus_wdata = 32'h0;
  logic        bus_resp;
  logic [31:0] bus_rdata;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  uart_mmio #(.CLKDIV(CLKDIV), .FIFO_LG(FIFO_LG)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wmask (bus_wmask),
    .bus_wdata (bus_wdata),
    .bus_resp  (bus_resp),
    .bus_rdata (bus_rdata),
    .uart_tx   (uart_tx),
    .uart_rx   (uart_rx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // free-running cycle counter for latency and frame spacing
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rd_exp_q [$];
  int          rd_cyc_q [$];
  string       rd_tag_q [$];
  logic [7:0]  tx_exp_q [$];

  logic mon_en   = 1'b1;
  logic b2b_on   = 1'b0;
  logic b2b_have = 1'b0;
  int   b2b_prev = 0;
  int   tx_frames = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // one bus access; the expected read data is queued for the response monitor
  task automatic bus_access(input logic we, input logic [1:0] addr, input logic [3:0] mask,
                            input logic [31:0] wdata, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wmask = mask; bus_wdata = wdata;
    rd_exp_q.push_back(exp);
    rd_cyc_q.push_back(cyc);
    rd_tag_q.push_back(tag);
    @(posedge clk);
    #1;
    bus_req = 1'b0; bus_we = 1'b0; bus_wmask = 4'h0; bus_wdata = 32'h0;
  endtask

  task automatic rd(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    bus_access(1'b0, addr, 4'h0, 32'h0, exp, tag);
  endtask

  task automatic wr_tx(input logic [7:0] b);
    tx_exp_q.push_back(b);
    bus_access(1'b1, A_TX, 4'hF, {24'h0, b}, 32'h0, "wr_tx_resp");
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // drive one 8N1 frame on uart_rx, changing the line on falling clock edges
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] sym;
    sym = {stop_bit, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      uart_rx = sym[i];
      repeat (CLKDIV) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  // bus response monitor: pop the scoreboard on each response
  initial begin : bus_mon
    logic [31:0] e;
    int          c;
    string       t;
    forever begin
      @(negedge clk);
      if (bus_resp === 1'b1) begin
        if (rd_exp_q.size() == 0) begin
          check_value("spurious_resp_rdata", bus_rdata, 32'hDEAD_BEEF);
        end else begin
          e = rd_exp_q.pop_front();
          c = rd_cyc_q.pop_front();
          t = rd_tag_q.pop_front();
          check_value(t, bus_rdata, e);
          check_value({t, "_latency"}, 32'(cyc - c), 32'd1);
        end
      end else if (bus_rdata !== 32'h0) begin
        check_value("rdata_without_resp", bus_rdata, 32'h0);
      end
    end
  end

  // serial TX monitor: decode frames mid-bit and compare to the expected byte queue
  initial begin : tx_mon
    logic [7:0] b;
    logic       st_bit;
    logic       sp_bit;
    int         t0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && uart_tx === 1'b0) begin
        t0 = cyc;
        repeat (CLKDIV / 2) @(negedge clk);
        st_bit = uart_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CLKDIV) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CLKDIV) @(negedge clk);
        sp_bit = uart_tx;
        if (mon_en) begin
          tx_frames++;
          check_value("tx_start_bit", 32'(st_bit), 32'h0);
          check_value("tx_stop_bit", 32'(sp_bit), 32'h1);
          if (tx_exp_q.size() == 0) begin
            check_value("tx_unexpected_byte", {24'h0, b}, 32'hFFFF_FFFF);
          end else begin
            check_value("tx_byte", {24'h0, b}, {24'h0, tx_exp_q.pop_front()});
          end
          if (b2b_on) begin
            if (b2b_have) begin
              check_value("tx_frame_spacing", 32'(t0 - b2b_prev), 32'(FRAME));
            end
            b2b_prev = t0;
            b2b_have = 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the end of the test sequence");
    $fatal(1, "watchdog");
  end

  logic [7:0] ovr_bytes  [9] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h99};
  logic [7:0] full_bytes [9] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};

  initial begin : main
    // reset state
    wait_cyc(3);
    check_value("reset_uart_tx", 32'(uart_tx), 32'h1);
    check_value("reset_bus_resp", 32'(bus_resp), 32'h0);
    check_value("reset_bus_rdata", bus_rdata, 32'h0);
    wait_cyc(2);
    rst = 1'b1;
    rd(A_STAT, 32'h05, "stat_after_reset");

    // accesses with no effect
    rd(A_TX, 32'h0, "read_tx_reg");
    rd(A_RSV, 32'h0, "read_reserved");
    bus_access(1'b1, A_STAT, 4'hF, 32'hFFFF_FFFF, 32'h0, "write_stat_resp");
    bus_access(1'b1, A_RX, 4'hF, 32'h0000_0011, 32'h0, "write_rx_resp");
    bus_access(1'b1, A_RSV, 4'hF, 32'h0000_0022, 32'h0, "write_rsv_resp");
    bus_access(1'b1, A_TX, 4'hE, 32'h0000_0077, 32'h0, "write_tx_nolane_resp");
    rd(A_STAT, 32'h05, "stat_after_noop_writes");
    rd(A_RX, 32'h0, "read_rx_empty");
    wait_cyc(30);

    // single byte frame
    wr_tx(8'hA5);
    rd(A_STAT, 32'h01, "stat_tx_busy");
    wait_cyc(FRAME + 10);
    rd(A_STAT, 32'h05, "stat_after_a5");

    // burst of 9 bytes, then a 10th while full
    b2b_on = 1'b1;
    b2b_have = 1'b0;
    for (int i = 0; i < 9; i++) wr_tx(8'(i));
    bus_access(1'b1, A_TX, 4'h1, 32'h0000_0009, 32'h0, "wr_tx_full_resp");
    rd(A_STAT, 32'h09, "stat_tx_full");
    wait_cyc(9 * FRAME + 40);
    b2b_on = 1'b0;
    rd(A_STAT, 32'h05, "stat_after_burst");

    // receive one byte, bracketing the moment it lands in the FIFO
    fork
      send_rx(8'h3C, 1'b1);
      begin
        @(negedge clk);
        wait_cyc(148);
        rd(A_STAT, 32'h05, "stat_rx_before_push");
        wait_cyc(7);
        rd(A_STAT, 32'h04, "stat_rx_after_push");
      end
    join
    rd(A_RX, 32'h3C, "rx_3c");
    rd(A_STAT, 32'h05, "stat_after_rx_3c");

    // overrun: 9 bytes without reading
    for (int i = 0; i < 9; i++) send_rx(ovr_bytes[i], 1'b1);
    wait_cyc(4);
    rd(A_STAT, 32'h16, "stat_overrun");
    rd(A_STAT, 32'h06, "stat_overrun_cleared");
    for (int i = 0; i < 8; i++) rd(A_RX, {24'h0, ovr_bytes[i]}, "rx_ovr_byte");
    rd(A_RX, 32'h0, "rx_empty_after_drain");
    rd(A_STAT, 32'h05, "stat_after_drain");

    // full FIFO with a pop in the same cycle as the 9th push
    for (int i = 0; i < 8; i++) send_rx(full_bytes[i], 1'b1);
    fork
      send_rx(full_bytes[8], 1'b1);
      begin
        @(negedge clk);
        wait_cyc(153);
        rd(A_RX, {24'h0, full_bytes[0]}, "rx_pop_at_push");
      end
    join
    wait_cyc(4);
    rd(A_STAT, 32'h06, "stat_full_no_ovr");
    for (int i = 1; i < 9; i++) rd(A_RX, {24'h0, full_bytes[i]}, "rx_full_byte");
    rd(A_STAT, 32'h05, "stat_after_full_drain");

    // start-bit glitch and framing error
    @(negedge clk);
    uart_rx = 1'b0;
    wait_cyc(3);
    uart_rx = 1'b1;
    wait_cyc(40);
    rd(A_STAT, 32'h05, "stat_after_glitch");
    send_rx(8'h55, 1'b0);
    wait_cyc(40);
    rd(A_STAT, 32'h05, "stat_after_framing_err");
    send_rx(8'hA3, 1'b1);
    wait_cyc(4);
    rd(A_RX, 32'hA3, "rx_after_framing_err");

    check_value("tx_exp_queue_drained", 32'(tx_exp_q.size()), 32'd0);
    check_value("tx_frame_count", 32'(tx_frames), 32'd10);

    // reset in the middle of a TX frame and an RX frame
    mon_en = 1'b0;
    bus_access(1'b1, A_TX, 4'h1, 32'h0000_0000, 32'h0, "wr_tx_pre_reset_resp");
    uart_rx = 1'b0;
    wait_cyc(40);
    check_value("tx_low_mid_frame", 32'(uart_tx), 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check_value("tx_high_async_reset", 32'(uart_tx), 32'h1);
    uart_rx = 1'b1;
    wait_cyc(3);
    check_value("tx_high_in_reset", 32'(uart_tx), 32'h1);
    rst = 1'b1;
    rd(A_STAT, 32'h05, "stat_after_mid_reset");
    wait_cyc(2 * FRAME);
    check_value("tx_idle_after_reset", 32'(uart_tx), 32'h1);
    rd(A_STAT, 32'h05, "stat_partial_rx_discarded");

    wait_cyc(3);
    check_value("bus_scoreboard_drained", 32'(rd_exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
